// File: rtl/approx_eval_pkg.sv
// Shared definitions for the approximate-adder evaluation blocks:
// sweep FSM state encoding and result-width helpers derived from WIDTH.
package approx_eval_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index counter width: both operands concatenated.
    function automatic int idx_w(input int w);
        return 2 * w;
    endfunction

    // Error-count width: must hold 2^(2w) pairs.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    // Sum of absolute errors: 2^(2w) pairs of at most 2^(w+1)-1 each.
    function automatic int abs_sum_w(input int w);
        return 3 * w + 1;
    endfunction

    // Sum of squared errors: 2^(2w) pairs of at most (2^(w+1)-1)^2 each.
    function automatic int sq_sum_w(input int w);
        return 4 * w + 2;
    endfunction

endpackage

// File: rtl/approx_err_accum.sv
// Two-stage error datapath: stage 1 captures the adder output together with
// the exact sum of the operands that produced it; stage 2 forms the absolute
// error and updates the four error accumulators.
module approx_err_accum
    import approx_eval_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          issue,
    input  logic [WIDTH-1:0]              op_a,
    input  logic [WIDTH-1:0]              op_b,
    input  logic [WIDTH:0]                sum_approx,
    output logic [cnt_w(WIDTH)-1:0]       err_count,
    output logic [WIDTH:0]                max_abs_err,
    output logic [abs_sum_w(WIDTH)-1:0]   sum_abs_err,
    output logic [sq_sum_w(WIDTH)-1:0]    sum_sq_err,
    output logic                          pipe_busy
);

    localparam int CW = cnt_w(WIDTH);
    localparam int AW = abs_sum_w(WIDTH);
    localparam int SW = sq_sum_w(WIDTH);

    logic             s1_valid;
    logic [WIDTH:0]   s1_sum;
    logic [WIDTH:0]   s1_exact;

    logic [WIDTH:0]     abs_err;
    logic [2*WIDTH+1:0] abs_ext;
    logic [2*WIDTH+1:0] sq_err;
    logic               nonzero;

    // Stage 1: sample the adder output and the exact reference for the
    // operand pair currently on op_a/op_b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_exact <= '0;
        end else begin
            s1_valid <= issue;
            s1_sum   <= sum_approx;
            s1_exact <= {1'b0, op_a} + {1'b0, op_b};
        end
    end

    // |sum_approx - exact| taken as larger minus smaller: identical to the
    // magnitude of the signed WIDTH+2-bit difference, without a negate.
    always_comb begin
        if (s1_sum >= s1_exact) begin
            abs_err = s1_sum - s1_exact;
        end else begin
            abs_err = s1_exact - s1_sum;
        end
        abs_ext = {{(WIDTH+1){1'b0}}, abs_err};
        sq_err  = abs_ext * abs_ext;
        nonzero = (abs_err != '0);
    end

    // Stage 2: accumulate; widths are sized so a full sweep cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
        end else if (clear) begin
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
        end else if (s1_valid) begin
            err_count   <= err_count + {{(CW-1){1'b0}}, nonzero};
            sum_abs_err <= sum_abs_err + {{(AW-WIDTH-1){1'b0}}, abs_err};
            sum_sq_err  <= sum_sq_err + {{(SW-2*WIDTH-2){1'b0}}, sq_err};
            if (abs_err > max_abs_err) begin
                max_abs_err <= abs_err;
            end
        end
    end

    assign pipe_busy = s1_valid;

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Exhaustive error-characterisation engine for an external approximate adder:
// walks every operand pair, samples the adder's sum one cycle later, and
// accumulates error statistics.
//
// Handshake: start is a single-cycle request honoured only in IDLE; busy is
// high from the cycle after start is accepted until done; done pulses for one
// cycle as busy falls, and the results are then stable until the next
// accepted start.
module approx_adder_err_monitor
    import approx_eval_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              op_a,
    output logic [WIDTH-1:0]              op_b,
    input  logic [WIDTH:0]                sum_approx,
    output logic [cnt_w(WIDTH)-1:0]       err_count,
    output logic [WIDTH:0]                max_abs_err,
    output logic [abs_sum_w(WIDTH)-1:0]   sum_abs_err,
    output logic [sq_sum_w(WIDTH)-1:0]    sum_sq_err,
    output state_t                        dbg_state
);

    localparam int IW = idx_w(WIDTH);
    localparam logic [IW-1:0] IDX_LAST = '1;

    state_t        state;
    logic [IW-1:0] idx;
    logic          accept;
    logic          issue;
    logic          pipe_busy;

    assign accept = start && (state == IDLE);
    assign issue  = (state == RUN);

    // Sweep controller and index generator; the index stops at the last
    // pair so op_a/op_b hold it through DRAIN and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx == IDX_LAST) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last pair is accumulated on the edge where the
                    // capture stage empties; results are final after it.
                    if (!pipe_busy) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign op_a      = idx[WIDTH-1:0];
    assign op_b      = idx[2*WIDTH-1:WIDTH];
    assign dbg_state = state;

    approx_err_accum #(
        .WIDTH (WIDTH)
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (accept),
        .issue       (issue),
        .op_a        (op_a),
        .op_b        (op_b),
        .sum_approx  (sum_approx),
        .err_count   (err_count),
        .max_abs_err (max_abs_err),
        .sum_abs_err (sum_abs_err),
        .sum_sq_err  (sum_sq_err),
        .pipe_busy   (pipe_busy)
    );

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Bench for approx_adder_err_monitor at WIDTH=4 (256-pair sweeps). The adder
// under test is emulated by a mode-selected behavioural model; expected
// statistics come from a plain-integer sweep over all pairs.
module tb_approx_adder_err_monitor;
    import approx_eval_pkg::*;

    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [W-1:0]          op_a;
    logic [W-1:0]          op_b;
    logic [W:0]            sum_approx;
    logic [2*W:0]          err_count;
    logic [W:0]            max_abs_err;
    logic [3*W:0]          sum_abs_err;
    logic [4*W+1:0]        sum_sq_err;
    state_t                dbg_state;

    int                    mode;
    logic [W:0]            rand_tab[N];
    logic [63:0]           exp_q[$];
    int                    errors = 0;
    int                    checks = 0;
    int                    done_cnt = 0;

    approx_adder_err_monitor #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .op_a        (op_a),
        .op_b        (op_b),
        .sum_approx  (sum_approx),
        .err_count   (err_count),
        .max_abs_err (max_abs_err),
        .sum_abs_err (sum_abs_err),
        .sum_sq_err  (sum_sq_err),
        .dbg_state   (dbg_state)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---- emulated adder under test (combinational from op_a/op_b) ----
    always_comb begin
        sum_approx = '0;
        case (mode)
            0:       sum_approx = {1'b0, op_a} + {1'b0, op_b};
            1:       sum_approx = '0;
            2:       sum_approx = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(1);
            default: sum_approx = rand_tab[{op_b, op_a}];
        endcase
    end

    // ---- reference model ----
    function automatic int approx_of(input int a, input int b);
        case (mode)
            0:       return a + b;
            1:       return 0;
            2:       return a + b + 1;
            default: return int'(rand_tab[b * (1 << W) + a]);
        endcase
    endfunction

    task automatic model_push();
        longint cnt = 0, mx = 0, sa = 0, sq = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                longint e  = longint'(approx_of(a, b)) - longint'(a + b);
                longint ae = (e < 0) ? -e : e;
                if (ae != 0) cnt++;
                if (ae > mx) mx = ae;
                sa += ae;
                sq += ae * ae;
            end
        end
        exp_q.push_back(64'(cnt));
        exp_q.push_back(64'(mx));
        exp_q.push_back(64'(sa));
        exp_q.push_back(64'(sq));
    endtask

    // ---- scoreboard ----
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag);
        logic [63:0] e_cnt, e_max, e_sa, e_sq;
        e_cnt = exp_q.pop_front();
        e_max = exp_q.pop_front();
        e_sa  = exp_q.pop_front();
        e_sq  = exp_q.pop_front();
        check({tag, ".err_count"},   64'(err_count),   e_cnt);
        check({tag, ".max_abs_err"}, 64'(max_abs_err), e_max);
        check({tag, ".sum_abs_err"}, 64'(sum_abs_err), e_sa);
        check({tag, ".sum_sq_err"},  64'(sum_sq_err),  e_sq);
        // Results must hold after done until a new start.
        repeat (4) @(posedge clk);
        #1;
        check({tag, ".hold_count"}, 64'(err_count),  e_cnt);
        check({tag, ".hold_sq"},    64'(sum_sq_err), e_sq);
    endtask

    // ---- drivers ----
    task automatic run_sweep(input string tag, input int repulse_at);
        int cyc;
        int busy_gaps;
        int d0;
        model_push();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        check({tag, ".busy_rise"}, 64'(busy), 64'(1));
        check({tag, ".state_run"}, 64'(dbg_state), 64'(RUN));
        cyc = 0;
        busy_gaps = 0;
        while (cyc < N + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == repulse_at);
            if (done) break;
            if (!busy) busy_gaps++;
        end
        start = 1'b0;
        check({tag, ".sweep_len"}, 64'(cyc), 64'(N + 2));
        check({tag, ".busy_gaps"}, 64'(busy_gaps), 64'(0));
        check({tag, ".busy_fall"}, 64'(busy), 64'(0));
        check({tag, ".op_a_last"}, 64'(op_a), 64'((1 << W) - 1));
        check({tag, ".op_b_last"}, 64'(op_b), 64'((1 << W) - 1));
        check_results(tag);
        check({tag, ".done_once"}, 64'(done_cnt - d0), 64'(1));
        check({tag, ".idle"}, 64'(dbg_state), 64'(IDLE));
    endtask

    task automatic abort_sweep(input int at);
        int d0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (at) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.busy",      64'(busy),        64'(0));
        check("abort.done",      64'(done),        64'(0));
        check("abort.err_count", 64'(err_count),   64'(0));
        check("abort.max",       64'(max_abs_err), 64'(0));
        check("abort.sum_abs",   64'(sum_abs_err), 64'(0));
        check("abort.sum_sq",    64'(sum_sq_err),  64'(0));
        check("abort.op_a",      64'(op_a),        64'(0));
        check("abort.state",     64'(dbg_state),   64'(IDLE));
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 10) @(posedge clk);
        #1;
        check("abort.no_done",   64'(done_cnt - d0), 64'(0));
        check("abort.still_idle", 64'(dbg_state),    64'(IDLE));
        check("abort.sum_abs_0", 64'(sum_abs_err),   64'(0));
    endtask

    // ---- directed sequence ----
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        for (int i = 0; i < N; i++) rand_tab[i] = (W+1)'($urandom_range(0, (1 << (W+1)) - 1));
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy",      64'(busy),        64'(0));
        check("reset.done",      64'(done),        64'(0));
        check("reset.err_count", 64'(err_count),   64'(0));
        check("reset.max",       64'(max_abs_err), 64'(0));
        check("reset.sum_abs",   64'(sum_abs_err), 64'(0));
        check("reset.sum_sq",    64'(sum_sq_err),  64'(0));
        check("reset.op_b",      64'(op_b),        64'(0));
        check("reset.state",     64'(dbg_state),   64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        mode = 0;
        run_sweep("exact", 0);
        mode = 1;
        run_sweep("zero", 0);
        mode = 2;
        run_sweep("plus1", 0);
        mode = 3;
        run_sweep("rand_a", 0);
        for (int i = 0; i < N; i++) rand_tab[i] = (W+1)'($urandom_range(0, (1 << (W+1)) - 1));
        run_sweep("rand_b", 0);
        mode = 1;
        run_sweep("repulse", 100);
        mode = 1;
        abort_sweep(100);
        mode = 0;
        run_sweep("after_abort", 0);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
